uart_mmio_host: RTL and testbench
=================================

// Module: uart_mmio_host
// PURPOSE
//  Bus initiator for the UART's MMIO register slave. Configures baud and enable after reset,
//  then polls STATUS and moves bytes between two valid/ready byte streams and the DATA register.
//  Lets the UART be driven by on-chip streaming logic with no CPU in the loop.
// PARAMETERS
//  BAUD_DIV_RESET  16'd27  divisor written to BAUD during init (50 MHz / (115200*16))
//  POLL_GAP        8       idle cycles between STATUS polls when no work pending (>=1)
//  ADDR_DATA       4'h0    DATA reg: write=push TX FIFO, read=pop RX FIFO
//  ADDR_STATUS     4'h1    STATUS reg: bit0 tx_full, bit1 rx_empty, bit2 rx_overrun
//  ADDR_CTRL       4'h2    CTRL reg: bit0 uart_en
//  ADDR_BAUD       4'h3    BAUD reg: [15:0] divisor
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   async active-low reset
//  s_tx_data      in   8   byte to transmit
//  s_tx_valid     in   1   s_tx_data valid
//  s_tx_ready     out  1   byte accepted this cycle
//  m_rx_data      out  8   received byte
//  m_rx_valid     out  1   m_rx_data valid
//  m_rx_ready     in   1   consumer accepts
//  addr           out  4   MMIO address
//  wdata          out  32  MMIO write data
//  rdata          in   32  MMIO read data, valid 1 cycle after rd_en
//  wr_en          out  1   MMIO write strobe (1 cycle)
//  rd_en          out  1   MMIO read strobe (1 cycle)
//  init_done      out  1   high once CTRL write completes
//  overrun_cnt    out  8   saturating count of STATUS polls showing rx_overrun
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low (clk, rst_n).
//  Reset: addr=0, wdata=0, wr_en=0, rd_en=0, s_tx_ready=0, m_rx_valid=0, m_rx_data=0,
//   init_done=0, overrun_cnt=0, state=INIT_BAUD, prio=TX.
//  At most one of wr_en/rd_en per cycle; every strobe is a single-cycle pulse.
//  FSM:
//   INIT_BAUD: wr_en, addr=ADDR_BAUD, wdata={16'b0,BAUD_DIV_RESET} -> INIT_CTRL
//   INIT_CTRL: wr_en, addr=ADDR_CTRL, wdata=32'h1; init_done<=1 -> POLL
//   POLL:      rd_en, addr=ADDR_STATUS -> POLL_WAIT
//   POLL_WAIT: capture rdata[2:0]; overrun_cnt+1 (sat 255) if bit2 -> DECIDE
//   DECIDE:    tx_ok = s_tx_valid & ~tx_full; rx_ok = ~rx_empty & ~m_rx_valid
//              both: serve prio, then flip prio; one: serve it; none -> GAP
//   TX_WR:     wr_en, addr=ADDR_DATA, wdata={24'b0,s_tx_data}, s_tx_ready=1 same cycle -> POLL
//   RX_RD:     rd_en, addr=ADDR_DATA -> RX_WAIT
//   RX_WAIT:   m_rx_data<=rdata[7:0], m_rx_valid<=1 -> POLL
//   GAP:       count POLL_GAP cycles -> POLL; abort to POLL early if s_tx_valid rises
//  Fresh STATUS read required before every DATA access (never act on stale status).
//  m_rx_valid holds until m_rx_valid&m_rx_ready; cleared that cycle. Single-entry buffer,
//   so RX_RD never issued while m_rx_valid=1 (no byte loss, backpressure into RX FIFO).
//  s_tx_ready only asserted in TX_WR; s_tx_data sampled that cycle.
//  TX-to-TX throughput: 1 byte per 4 cycles (POLL, POLL_WAIT, DECIDE, TX_WR).
//  rst_n low mid-transaction: all strobes drop immediately; init sequence reruns.
// CONFIGURATION
//  UART_HOST_IRQ_EN defined: adds inputs rx_ready_irq, tx_empty_irq (1 bit each).
//   GAP exits only on s_tx_valid or rx_ready_irq (no timed polling; zero idle bus traffic).
//   tx_empty_irq forces one immediate POLL. Init writes CTRL=32'h3 (uart_en + rx irq enable).
//  Undefined: no irq ports; GAP uses POLL_GAP timer as above; CTRL=32'h1.
// STRUCTURE
//  uart_pkg: ADDR_* defaults, STATUS bit indices, host FSM state enum.
//  Sub-module uart_mmio_host_rxbuf: 1-entry valid/ready output register (load, pop, full).
// TESTING
//  Reset release, slave model idle -> cycle1 wr BAUD wdata=0x1B, cycle2 wr CTRL 0x1, init_done=1.
//  s_tx_valid with 0xA5, STATUS=0b010 -> rd STATUS, then wr DATA 0xA5 with s_tx_ready pulse.
//  STATUS tx_full=1 for 3 polls then 0 -> no DATA write until 4th poll; byte 0x3C sent once.
//  RX model holds 0x11,0x22; m_rx_ready=0 -> one DATA read, m_rx_valid=1 data 0x11, no 2nd read
//   until handshake; then 0x22 delivered.
//  TX pending + rx_empty=0 over 4 decisions -> order TX,RX,TX,RX (prio alternates).
//  STATUS bit2=1 on 300 polls -> overrun_cnt=255; rst_n pulse mid RX_WAIT -> all outputs reset.

Source files
------------

// File: rtl/uart_mmio_host_pkg.sv
// Shared definitions for the UART MMIO host: register map, STATUS bit positions,
// host FSM state and arbitration priority types.
package uart_mmio_host_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_CTRL   = 4'h2;
  localparam logic [3:0] ADDR_BAUD   = 4'h3;

  localparam int STATUS_TX_FULL    = 0;
  localparam int STATUS_RX_EMPTY   = 1;
  localparam int STATUS_RX_OVERRUN = 2;

  typedef enum logic [3:0] {
    INIT_BAUD,
    INIT_CTRL,
    POLL,
    POLL_WAIT,
    DECIDE,
    TX_WR,
    RX_RD,
    RX_WAIT,
    GAP
  } hostState_e;

  typedef enum logic {
    PRIO_TX,
    PRIO_RX
  } prio_e;

  // Saturating 8-bit increment used by the overrun counter.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_mmio_host_if.sv
// MMIO register bus between the host (master) and the UART register slave.
interface uart_mmio_host_if;

  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wr_en;
  logic        rd_en;

  modport master (output addr, output wdata, output wr_en, output rd_en, input rdata);
  modport slave  (input addr, input wdata, input wr_en, input rd_en, output rdata);

endinterface

// File: rtl/uart_mmio_host_rxbuf.sv
// Single-entry valid/ready output register for received bytes. A load fills the
// entry; a consumer handshake empties it.
module uart_mmio_host_rxbuf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] loadData_i,
  input  logic       popReady_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       full_o
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && popReady_i) begin
      valid_d = 1'b0;
    end
    if (load_i) begin
      data_d  = loadData_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign full_o  = valid_q;

endmodule

// File: rtl/uart_mmio_host.sv
// MMIO bus initiator that initialises the UART and shuttles bytes between two
// byte streams and the DATA register. Optional feature macro: UART_HOST_IRQ_EN.
module uart_mmio_host
  import uart_mmio_host_pkg::*;
#(
  parameter logic [15:0] BAUD_DIV_RESET = 16'd27,
  parameter int          POLL_GAP       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_tx_data_i,
  input  logic       s_tx_valid_i,
  output logic       s_tx_ready_o,
  output logic [7:0] m_rx_data_o,
  output logic       m_rx_valid_o,
  input  logic       m_rx_ready_i,
  output logic       init_done_o,
  output logic [7:0] overrun_cnt_o,
`ifdef UART_HOST_IRQ_EN
  input  logic       rx_ready_irq_i,
  input  logic       tx_empty_irq_i,
`endif
  uart_mmio_host_if.master bus
);

`ifdef UART_HOST_IRQ_EN
  localparam logic [31:0] CTRL_INIT = 32'h3;
`else
  localparam logic [31:0] CTRL_INIT = 32'h1;
`endif
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  hostState_e  state_q, state_d;
  prio_e       prio_q, prio_d;
  logic [2:0]  status_q, status_d;
  logic [7:0]  overrunCnt_q, overrunCnt_d;
  logic        initDone_q, initDone_d;
  logic [7:0]  gapCnt_q, gapCnt_d;
  logic        txValidPrev_q;

  logic [3:0]  addrC;
  logic [31:0] wdataC;
  logic        wrEnC;
  logic        rdEnC;
  logic        txReadyC;
  logic        rxLoad;
  logic        rxFull;
  logic        txOk;
  logic        rxOk;
  logic        txValidRise;
  logic        gapExit;
  logic        unusedRdataBits;

  assign unusedRdataBits = ^bus.rdata[31:8];
  assign txValidRise     = s_tx_valid_i & ~txValidPrev_q;

`ifdef UART_HOST_IRQ_EN
  assign gapExit = txValidRise | rx_ready_irq_i | tx_empty_irq_i;
`else
  assign gapExit = txValidRise | (gapCnt_q == GAP_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT_BAUD;
      prio_q        <= PRIO_TX;
      status_q      <= 3'b000;
      overrunCnt_q  <= 8'h00;
      initDone_q    <= 1'b0;
      gapCnt_q      <= 8'h00;
      txValidPrev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      status_q      <= status_d;
      overrunCnt_q  <= overrunCnt_d;
      initDone_q    <= initDone_d;
      gapCnt_q      <= gapCnt_d;
      txValidPrev_q <= s_tx_valid_i;
    end
  end

  // Decisions only ever use the STATUS word captured by the poll just before them.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    status_d     = status_q;
    overrunCnt_d = overrunCnt_q;
    initDone_d   = initDone_q;
    gapCnt_d     = gapCnt_q;
    addrC        = 4'h0;
    wdataC       = 32'h0;
    wrEnC        = 1'b0;
    rdEnC        = 1'b0;
    txReadyC     = 1'b0;
    rxLoad       = 1'b0;
    txOk         = s_tx_valid_i & ~status_q[STATUS_TX_FULL];
    rxOk         = ~status_q[STATUS_RX_EMPTY] & ~rxFull;

    case (state_q)
      INIT_BAUD: begin
        wrEnC   = 1'b1;
        addrC   = ADDR_BAUD;
        wdataC  = {16'b0, BAUD_DIV_RESET};
        state_d = INIT_CTRL;
      end
      INIT_CTRL: begin
        wrEnC      = 1'b1;
        addrC      = ADDR_CTRL;
        wdataC     = CTRL_INIT;
        initDone_d = 1'b1;
        state_d    = POLL;
      end
      POLL: begin
        rdEnC   = 1'b1;
        addrC   = ADDR_STATUS;
        state_d = POLL_WAIT;
      end
      POLL_WAIT: begin
        status_d = bus.rdata[2:0];
        if (bus.rdata[STATUS_RX_OVERRUN]) begin
          overrunCnt_d = satInc8(overrunCnt_q);
        end
        state_d = DECIDE;
      end
      DECIDE: begin
        if (txOk && rxOk) begin
          state_d = (prio_q == PRIO_TX) ? TX_WR : RX_RD;
          prio_d  = (prio_q == PRIO_TX) ? PRIO_RX : PRIO_TX;
        end else if (txOk) begin
          state_d = TX_WR;
        end else if (rxOk) begin
          state_d = RX_RD;
        end else begin
          gapCnt_d = 8'h00;
          state_d  = GAP;
        end
      end
      TX_WR: begin
        wrEnC    = 1'b1;
        addrC    = ADDR_DATA;
        wdataC   = {24'b0, s_tx_data_i};
        txReadyC = 1'b1;
        state_d  = POLL;
      end
      RX_RD: begin
        rdEnC   = 1'b1;
        addrC   = ADDR_DATA;
        state_d = RX_WAIT;
      end
      RX_WAIT: begin
        rxLoad  = 1'b1;
        state_d = POLL;
      end
      GAP: begin
        gapCnt_d = gapCnt_q + 8'd1;
        if (gapExit) begin
          state_d = POLL;
        end
      end
      default: begin
        state_d = INIT_BAUD;
      end
    endcase
  end

  uart_mmio_host_rxbuf u_rxbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (rxLoad),
    .loadData_i (bus.rdata[7:0]),
    .popReady_i (m_rx_ready_i),
    .data_o     (m_rx_data_o),
    .valid_o    (m_rx_valid_o),
    .full_o     (rxFull)
  );

  // Bus outputs are gated by rst_n so an in-flight strobe drops the moment reset asserts.
  assign bus.wr_en     = rst_n & wrEnC;
  assign bus.rd_en     = rst_n & rdEnC;
  assign bus.addr      = rst_n ? addrC : 4'h0;
  assign bus.wdata     = rst_n ? wdataC : 32'h0;
  assign s_tx_ready_o  = rst_n & txReadyC;
  assign init_done_o   = initDone_q;
  assign overrun_cnt_o = overrunCnt_q;

endmodule

// File: tb/tb_uart_mmio_host.sv
// Directed bench for uart_mmio_host with a behavioural MMIO register slave
// that logs every bus access.
module tb_uart_mmio_host;
  import uart_mmio_host_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sTxData;
  logic       sTxValid;
  logic       sTxReady;
  logic [7:0] mRxData;
  logic       mRxValid;
  logic       mRxReady;
  logic       initDone;
  logic [7:0] overrunCnt;

  always #5 clk = ~clk;

  uart_mmio_host_if bus ();

  uart_mmio_host dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_tx_data_i   (sTxData),
    .s_tx_valid_i  (sTxValid),
    .s_tx_ready_o  (sTxReady),
    .m_rx_data_o   (mRxData),
    .m_rx_valid_o  (mRxValid),
    .m_rx_ready_i  (mRxReady),
    .init_done_o   (initDone),
    .overrun_cnt_o (overrunCnt),
    .bus           (bus)
  );

  typedef struct {
    bit          isWr;
    logic [3:0]  addr;
    logic [31:0] data;
    int          reads;
    int          cyc;
  } busEv_t;

  busEv_t     evLog[$];
  logic [7:0] rxGot[$];
  logic [7:0] rxMem [0:15];
  logic [3:0] rxWrPtr;
  logic [3:0] rxRdPtr = 4'h0;
  int         cycle = 0;
  int         statusReads = 0;
  int         dataReads = 0;
  int         bothStrobes = 0;
  int         txFullUntil;
  logic       forceOverrun;

  int checks = 0;
  int errors = 0;

  // Register slave: STATUS is built from the bench's knobs, DATA reads pop rxMem.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (bus.wr_en && bus.rd_en) bothStrobes++;
    if (bus.wr_en) evLog.push_back('{1'b1, bus.addr, bus.wdata, statusReads, cycle});
    if (bus.rd_en) begin
      evLog.push_back('{1'b0, bus.addr, 32'h0, statusReads, cycle});
      if (bus.addr == ADDR_STATUS) begin
        bus.rdata <= {29'b0, forceOverrun, (rxRdPtr == rxWrPtr), (statusReads < txFullUntil)};
        statusReads++;
      end else if (bus.addr == ADDR_DATA) begin
        bus.rdata <= {24'b0, rxMem[rxRdPtr]};
        if (rxRdPtr != rxWrPtr) rxRdPtr <= rxRdPtr + 4'd1;
        dataReads++;
      end else begin
        bus.rdata <= 32'hDEADBEEF;
      end
    end
    if (mRxValid && mRxReady) rxGot.push_back(mRxData);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_addr"}, 32'(bus.addr), 32'h0);
    checkOutput({tag, "_wdata"}, bus.wdata, 32'h0);
    checkOutput({tag, "_wr_en"}, 32'(bus.wr_en), 32'h0);
    checkOutput({tag, "_rd_en"}, 32'(bus.rd_en), 32'h0);
    checkOutput({tag, "_tx_ready"}, 32'(sTxReady), 32'h0);
    checkOutput({tag, "_rx_valid"}, 32'(mRxValid), 32'h0);
    checkOutput({tag, "_rx_data"}, 32'(mRxData), 32'h0);
    checkOutput({tag, "_init_done"}, 32'(initDone), 32'h0);
    checkOutput({tag, "_overrun"}, 32'(overrunCnt), 32'h0);
  endtask

  // Offers one TX byte and waits (bounded) for the accepting ready pulse.
  task automatic applyStimulus(input logic [7:0] data, input bit last, output bit ok);
    sTxData  = data;
    sTxValid = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sTxReady) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (last || !ok) begin
      sTxValid = 1'b0;
      sTxData  = 8'h00;
    end
  endtask

  function automatic int findDataEv(input int fromIdx, input int nth);
    int seen = 0;
    for (int i = fromIdx; i < evLog.size(); i++) begin
      if (evLog[i].addr == ADDR_DATA) begin
        if (seen == nth) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  task automatic waitStatusPoll(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rd_en && bus.addr == ADDR_STATUS) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    automatic bit ok;
    automatic int markEv;
    automatic int markReads;
    automatic int markData;
    automatic int markGot;
    automatic int idx;
    automatic int idx2;

    rst_n = 1'b0; sTxData = 8'h00; sTxValid = 1'b0; mRxReady = 1'b0;
    forceOverrun = 1'b0; txFullUntil = 0; rxWrPtr = 4'h0;
    for (int i = 0; i < 16; i++) rxMem[i] = 8'h00;

    repeat (3) @(negedge clk);
    checkResetState("reset");

    // Init sequence: BAUD write in the first cycle, CTRL write in the second.
    rst_n = 1'b1;
    #1;
    checkOutput("init_baud_wr", 32'(bus.wr_en), 32'h1);
    checkOutput("init_baud_addr", 32'(bus.addr), 32'(ADDR_BAUD));
    checkOutput("init_baud_wdata", bus.wdata, 32'h1B);
    @(negedge clk);
    checkOutput("init_ctrl_wr", 32'(bus.wr_en), 32'h1);
    checkOutput("init_ctrl_addr", 32'(bus.addr), 32'(ADDR_CTRL));
    checkOutput("init_ctrl_wdata", bus.wdata, 32'h1);
    checkOutput("init_done_early", 32'(initDone), 32'h0);
    @(negedge clk);
    checkOutput("init_done", 32'(initDone), 32'h1);
    checkOutput("first_poll_rd", 32'(bus.rd_en), 32'h1);
    checkOutput("first_poll_addr", 32'(bus.addr), 32'(ADDR_STATUS));

    // Single TX byte preceded by a fresh STATUS read.
    markEv = evLog.size();
    applyStimulus(8'hA5, 1'b1, ok);
    checkOutput("tx_a5_accepted", 32'(ok), 32'h1);
    idx = findDataEv(markEv, 0);
    checkOutput("tx_a5_found", 32'(idx >= 1), 32'h1);
    if (idx >= 1) begin
      checkOutput("tx_a5_is_write", 32'(evLog[idx].isWr), 32'h1);
      checkOutput("tx_a5_wdata", evLog[idx].data, 32'hA5);
      checkOutput("tx_a5_prev_status", {27'b0, evLog[idx-1].isWr, evLog[idx-1].addr}, {27'b0, 1'b0, ADDR_STATUS});
    end
    checkOutput("tx_ready_low_after", 32'(sTxReady), 32'h0);

    // Back-to-back TX: one byte every four cycles.
    markEv = evLog.size();
    applyStimulus(8'h5A, 1'b0, ok);
    applyStimulus(8'hC3, 1'b1, ok);
    idx  = findDataEv(markEv, 0);
    idx2 = findDataEv(markEv, 1);
    checkOutput("tx_b2b_found", 32'((idx >= 0) && (idx2 >= 0)), 32'h1);
    if ((idx >= 0) && (idx2 >= 0)) begin
      checkOutput("tx_b2b_first", evLog[idx].data, 32'h5A);
      checkOutput("tx_b2b_second", evLog[idx2].data, 32'hC3);
      checkOutput("tx_b2b_spacing", 32'(evLog[idx2].cyc - evLog[idx].cyc), 32'd4);
    end

    // tx_full for three polls: the write must follow the fourth poll, exactly once.
    @(negedge clk);
    markReads   = statusReads;
    txFullUntil = statusReads + 3;
    markEv      = evLog.size();
    applyStimulus(8'h3C, 1'b1, ok);
    checkOutput("tx_full_accepted", 32'(ok), 32'h1);
    repeat (30) @(negedge clk);
    idx  = findDataEv(markEv, 0);
    idx2 = findDataEv(markEv, 1);
    checkOutput("tx_full_found", 32'(idx >= 0), 32'h1);
    checkOutput("tx_full_single", 32'(idx2 < 0), 32'h1);
    if (idx >= 0) begin
      checkOutput("tx_full_wdata", evLog[idx].data, 32'h3C);
      checkOutput("tx_full_polls", 32'(evLog[idx].reads - markReads), 32'd4);
    end

    // RX backpressure: one read, then nothing until the consumer takes the byte.
    markData = dataReads;
    markGot  = rxGot.size();
    rxMem[rxWrPtr]        = 8'h11;
    rxMem[rxWrPtr + 4'd1] = 8'h22;
    rxWrPtr = rxWrPtr + 4'd2;
    repeat (40) @(negedge clk);
    checkOutput("rx_first_valid", 32'(mRxValid), 32'h1);
    checkOutput("rx_first_data", 32'(mRxData), 32'h11);
    checkOutput("rx_first_reads", 32'(dataReads - markData), 32'd1);
    repeat (40) @(negedge clk);
    checkOutput("rx_held_reads", 32'(dataReads - markData), 32'd1);
    checkOutput("rx_held_data", 32'(mRxData), 32'h11);
    mRxReady = 1'b1;
    @(posedge clk);
    #1;
    mRxReady = 1'b0;
    checkOutput("rx_pop_count", 32'(rxGot.size() - markGot), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mRxValid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("rx_second_valid", 32'(ok), 32'h1);
    checkOutput("rx_second_data", 32'(mRxData), 32'h22);
    checkOutput("rx_second_reads", 32'(dataReads - markData), 32'd2);
    mRxReady = 1'b1;
    @(posedge clk);
    #1;

    // Contention: both TX and RX pending, priority alternates TX,RX,TX,RX.
    waitStatusPoll(ok);
    checkOutput("prio_align", 32'(ok), 32'h1);
    repeat (3) @(negedge clk);
    markEv  = evLog.size();
    markGot = rxGot.size();
    rxMem[rxWrPtr]        = 8'h33;
    rxMem[rxWrPtr + 4'd1] = 8'h44;
    rxWrPtr = rxWrPtr + 4'd2;
    applyStimulus(8'h55, 1'b0, ok);
    applyStimulus(8'h66, 1'b1, ok);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      idx = findDataEv(markEv, k);
      checkOutput($sformatf("prio_order_%0d", k), (idx >= 0) ? 32'(evLog[idx].isWr) : 32'hFFFF_FFFF,
                  ((k % 2) == 0) ? 32'h1 : 32'h0);
    end
    idx  = findDataEv(markEv, 0);
    idx2 = findDataEv(markEv, 2);
    if ((idx >= 0) && (idx2 >= 0)) begin
      checkOutput("prio_tx_first", evLog[idx].data, 32'h55);
      checkOutput("prio_tx_second", evLog[idx2].data, 32'h66);
    end
    checkOutput("prio_rx_count", 32'(rxGot.size() - markGot), 32'd2);
    if (rxGot.size() - markGot == 2) begin
      checkOutput("prio_rx_byte0", 32'(rxGot[markGot]), 32'h33);
      checkOutput("prio_rx_byte1", 32'(rxGot[markGot + 1]), 32'h44);
    end

    // Overrun counting and saturation.
    @(negedge clk);
    forceOverrun = 1'b1;
    markReads    = statusReads;
    for (int i = 0; i < 500 && statusReads < markReads + 10; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("overrun_10", 32'(overrunCnt), 32'd10);
    for (int i = 0; i < 5000 && statusReads < markReads + 300; i++) @(negedge clk);
    checkOutput("overrun_polls_reached", 32'(statusReads >= markReads + 300), 32'h1);
    repeat (2) @(negedge clk);
    checkOutput("overrun_sat", 32'(overrunCnt), 32'd255);

    // Reset asserted while a DATA read is completing.
    forceOverrun = 1'b0;
    mRxReady     = 1'b0;
    rxMem[rxWrPtr] = 8'h77;
    rxWrPtr = rxWrPtr + 4'd1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.rd_en && bus.addr == ADDR_DATA) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("rst_rx_rd_seen", 32'(ok), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rerun_baud_wr", 32'(bus.wr_en), 32'h1);
    checkOutput("rerun_baud_addr", 32'(bus.addr), 32'(ADDR_BAUD));
    checkOutput("rerun_baud_wdata", bus.wdata, 32'h1B);
    repeat (4) @(negedge clk);

    checkOutput("single_strobe", 32'(bothStrobes), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
